data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store port. Accepts one request
//  at a time from the datapath (initiator) and performs a byte-masked write or
//  a word read on an internal word array.

---
 rtl/data_mem_responder_pkg.sv | 12 +
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder_array.sv | 25 ++
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the data-port memory responder.
package data_mem_responder_pkg;
   localparam int XLEN   = 32;
   localparam int MASK_W = XLEN / 8;

   typedef enum logic [1:0] {
      DMR_IDLE   = 2'd0,
      DMR_WAIT   = 2'd1,
      DMR_ACCESS = 2'd2,
      DMR_RESP   = 2'd3
   } dmr_state_e;
endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between the core datapath and the responder.
interface data_mem_responder_if;
   import data_mem_responder_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [XLEN-1:0]   req_addr;
   logic              req_wen;
   logic [XLEN-1:0]   req_wdata;
   logic [MASK_W-1:0] req_wmask;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder_array.sv
// Word array with byte-enabled synchronous write and registered read.
module dm_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MASK_W-1:0] be,
   input  logic [IDX_W-1:0]  idx,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);
   logic [XLEN-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (be[b]) r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata <= r_mem[idx];
   end
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: latch request, wait LATENCY cycles,
// access the array once, then hold the response until the initiator takes it.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          LATENCY   = 2
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);
   localparam int              IDX_W = $clog2(DEPTH);
   localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH) << 2;
   localparam logic [3:0]      LAT   = 4'(LATENCY);

   dmr_state_e        r_state, w_next;
   logic [3:0]        r_cnt;
   logic [XLEN-1:0]   r_addr, r_wdata;
   logic              r_wen;
   logic [MASK_W-1:0] r_wmask;
   logic              r_err, r_rd_ok;

   logic [XLEN-1:0]   w_off, w_rdata;
   logic [IDX_W-1:0]  w_idx;
   logic              w_err, w_we;

   // Unsigned 32-bit compares: an address below base wraps w_off to a huge value
   // and is caught by both terms, so it can never alias into the array.
   assign w_off = r_addr - BASE_ADDR;
   assign w_idx = w_off[IDX_W+1:2];
   assign w_err = (r_addr[1:0] != 2'b00) | (r_addr < BASE_ADDR) | (w_off >= SPAN);
   assign w_we  = (r_state == DMR_ACCESS) & r_wen & ~w_err;

   dm_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .we    (w_we),
      .be    (r_wmask),
      .idx   (w_idx),
      .wdata (r_wdata),
      .rdata (w_rdata)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         DMR_IDLE:   if (bus.req_valid) w_next = (LATENCY == 0) ? DMR_ACCESS : DMR_WAIT;
         DMR_WAIT:   if (r_cnt == 4'd1) w_next = DMR_ACCESS;
         DMR_ACCESS: w_next = DMR_RESP;
         DMR_RESP:   if (bus.rsp_ready) w_next = DMR_IDLE;
         default:    w_next = DMR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= DMR_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_err   <= 1'b0;
         r_rd_ok <= 1'b0;
      end else begin
         unique case (r_state)
            DMR_IDLE: if (bus.req_valid) begin
               r_addr  <= bus.req_addr;
               r_wen   <= bus.req_wen;
               r_wdata <= bus.req_wdata;
               r_wmask <= bus.req_wmask;
               r_cnt   <= LAT;
            end
            DMR_WAIT:   r_cnt <= r_cnt - 4'd1;
            DMR_ACCESS: begin
               r_err   <= w_err;
               r_rd_ok <= ~r_wen & ~w_err;
            end
            DMR_RESP: if (bus.rsp_ready) begin
               r_err   <= 1'b0;
               r_rd_ok <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // The array read register only moves with r_addr, which is frozen outside IDLE,
   // so gating it with r_rd_ok gives stable read data and zero for writes/errors.
   assign bus.req_ready = (r_state == DMR_IDLE);
   assign bus.rsp_valid = (r_state == DMR_RESP);
   assign bus.rsp_err   = r_err;
   assign bus.rsp_rdata = r_rd_ok ? w_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: directed scenarios plus random streams on LATENCY=2 and LATENCY=0 builds.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if bus0();
   data_mem_responder_if bus1();

   logic        sel = 1'b0;
   logic        t_valid = 1'b0, t_wen = 1'b0, t_rsp_ready = 1'b1;
   logic [31:0] t_addr = '0, t_wdata = '0;
   logic [3:0]  t_wmask = '0;

   assign bus0.req_valid = t_valid & ~sel;
   assign bus1.req_valid = t_valid & sel;
   assign bus0.req_addr  = t_addr;   assign bus1.req_addr  = t_addr;
   assign bus0.req_wen   = t_wen;    assign bus1.req_wen   = t_wen;
   assign bus0.req_wdata = t_wdata;  assign bus1.req_wdata = t_wdata;
   assign bus0.req_wmask = t_wmask;  assign bus1.req_wmask = t_wmask;
   assign bus0.rsp_ready = t_rsp_ready;
   assign bus1.rsp_ready = t_rsp_ready;

   logic        w_req_ready, w_rsp_valid, w_rsp_err;
   logic [31:0] w_rsp_rdata;
   assign w_req_ready = sel ? bus1.req_ready : bus0.req_ready;
   assign w_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
   assign w_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
   assign w_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

   data_mem_responder #(.LATENCY(2)) u_dut0 (.clk(clk), .rst(rst_n), .bus(bus0.slave));
   data_mem_responder #(.LATENCY(0)) u_dut1 (.clk(clk), .rst(rst_n), .bus(bus1.slave));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: byte-addressed rules applied to a sparse word map per DUT
   logic [31:0] ref0 [int unsigned];
   logic [31:0] ref1 [int unsigned];

   function automatic bit exp_err(input logic [31:0] a);
      longint unsigned la = longint'(a);
      return (a[1:0] != 2'b00) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4096);
   endfunction

   task automatic model_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] m, output logic [31:0] rd, output logic er);
      int unsigned key = a >> 2;
      logic [31:0] cur;
      er = exp_err(a);
      rd = '0;
      if (!er) begin
         if (sel) cur = ref1.exists(key) ? ref1[key] : '0;
         else     cur = ref0.exists(key) ? ref0[key] : '0;
         if (w) begin
            for (int b = 0; b < 4; b++) if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
            if (sel) ref1[key] = cur; else ref0[key] = cur;
         end else begin
            rd = cur;
         end
      end
   endtask

   // lat = negedges from the accepting IDLE cycle to the first cycle with rsp_valid
   task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output logic er,
                       output int lat);
      int n = 0;
      @(negedge clk);
      t_addr = a; t_wen = w; t_wdata = d; t_wmask = m; t_valid = 1'b1; t_rsp_ready = 1'b1;
      while (!w_req_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept", {31'd0, w_req_ready}, 32'd1);
      @(posedge clk); #1 t_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!w_rsp_valid && lat < 50);
      chk("rsp_valid", {31'd0, w_rsp_valid}, 32'd1);
      rd = w_rsp_rdata;
      er = w_rsp_err;
      @(posedge clk);
   endtask

   task automatic run_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m, output logic [31:0] rd);
      logic [31:0] erd; logic eer, er; int lat;
      model_op(a, w, d, m, erd, eer);
      xact(a, w, d, m, rd, er, lat);
      chk("rdata", rd, erd);
      chk("err", {31'd0, er}, {31'd0, eer});
      chk("latency", lat, sel ? 32'd2 : 32'd4);
   endtask

   logic [31:0] bad [6] = '{32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0002,
                            32'hFFFF_FFFC, 32'h0000_0010, 32'h8000_0FFF};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a;
      int n;

      // reset state
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_rsp_valid", {31'd0, w_rsp_valid}, 32'd0);
         chk("rst_rsp_err",   {31'd0, w_rsp_err},   32'd0);
         chk("rst_rsp_rdata", w_rsp_rdata, 32'd0);
         chk("rst_req_ready", {31'd0, w_req_ready}, 32'd1);
      end
      sel = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // 1: write then read
      run_op(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, rd);
      run_op(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd);
      chk("t1_read", rd, 32'hDEAD_BEEF);

      // 2: partial-lane merge
      run_op(BASE + 32'h20, 1'b1, 32'h1122_3344, 4'hF, rd);
      run_op(BASE + 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, rd);
      run_op(BASE + 32'h20, 1'b0, 32'h0, 4'h0, rd);
      chk("t2_merge", rd, 32'h11BB_33DD);
      run_op(BASE + 32'h20, 1'b1, 32'hFFFF_FFFF, 4'h0, rd);

      // 3: error addresses, no aliasing into word 0
      run_op(BASE, 1'b1, 32'hCAFE_F00D, 4'hF, rd);
      for (int i = 0; i < 3; i++) run_op(bad[i], 1'b0, 32'h0, 4'h0, rd);
      run_op(32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, rd);
      run_op(BASE, 1'b0, 32'h0, 4'h0, rd);
      chk("t3_no_alias", rd, 32'hCAFE_F00D);
      run_op(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd);
      chk("t3_unchanged", rd, 32'hDEAD_BEEF);

      // 4: response backpressure with a second request held
      @(negedge clk);
      t_addr = BASE + 32'h10; t_wen = 1'b0; t_valid = 1'b1; t_rsp_ready = 1'b0;
      chk("t4_ready", {31'd0, w_req_ready}, 32'd1);
      @(posedge clk); #1 t_addr = BASE + 32'h20;
      n = 0;
      do begin @(negedge clk); n++; end while (!w_rsp_valid && n < 20);
      chk("t4_latency", n, 32'd4);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", {31'd0, w_rsp_valid}, 32'd1);
         chk("t4_hold_rdata", w_rsp_rdata, 32'hDEAD_BEEF);
         chk("t4_hold_err",   {31'd0, w_rsp_err},   32'd0);
         chk("t4_hold_ready", {31'd0, w_req_ready}, 32'd0);
         @(negedge clk);
      end
      t_rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_idle_ready", {31'd0, w_req_ready}, 32'd1);
      chk("t4_idle_valid", {31'd0, w_rsp_valid}, 32'd0);
      chk("t4_idle_err",   {31'd0, w_rsp_err},   32'd0);
      @(posedge clk); #1 t_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!w_rsp_valid && n < 20);
      chk("t4_held_latency", n, 32'd4);
      chk("t4_held_rdata", w_rsp_rdata, 32'h11BB_33DD);
      @(posedge clk);

      // 5: reset during WAIT aborts a write
      run_op(BASE + 32'h30, 1'b1, 32'h0000_0001, 4'hF, rd);
      @(negedge clk);
      t_addr = BASE + 32'h30; t_wen = 1'b1; t_wdata = 32'h5555_5555; t_wmask = 4'hF; t_valid = 1'b1;
      @(posedge clk); #1 t_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", {31'd0, w_rsp_valid}, 32'd0);
      chk("t5_rst_err",   {31'd0, w_rsp_err},   32'd0);
      chk("t5_rst_rdata", w_rsp_rdata, 32'd0);
      chk("t5_rst_ready", {31'd0, w_req_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;
      run_op(BASE + 32'h30, 1'b0, 32'h0, 4'h0, rd);
      chk("t5_aborted", rd, 32'h0000_0001);

      // 6: random streams, LATENCY=0 build first, then LATENCY=2
      for (int s = 1; s >= 0; s--) begin
         @(negedge clk); sel = s[0];
         for (int i = 0; i < 16; i++) run_op(BASE + 4*i, 1'b1, $urandom, 4'hF, rd);
         for (int i = 0; i < (s ? 200 : 60); i++) begin
            if ($urandom_range(0, 9) < 8) a = BASE + 4 * $urandom_range(0, 15);
            else                          a = bad[$urandom_range(0, 5)];
            run_op(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
